datamem_bytelane: RTL and testbench
===================================

Name: datamem_bytelane

Overview:
- Parametrised successor to the single-port word data memory in the MEM stage of the pipelined MIPS core.
- Adds byte, halfword and word accesses (lb/lbu/lh/lhu/lw/sb/sh/sw) on byte addresses.
- Reads are synchronous with 1-cycle latency, with a valid strobe.
- Detects misaligned and out-of-range accesses and suppresses them.
- Keeps a sticky error flag for the hazard/exception logic.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096.
- ADDR_W, 32, width of byte address A.
- INIT_PATTERN, 1. 1 = word i initialised to i at time zero. 0 = all words initialised to zero.

Ports:
- clk  in  1  clock; all state changes on rising edge only.
- rst_n  in  1  asynchronous active-low reset.
- WE  in  1  store request, sampled at posedge clk.
- memread  in  1  load request, sampled at posedge clk.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 sign-extends sub-word data, 0 zero-extends.
- A  in  ADDR_W  byte address.
- WD  in  32  store data; sub-word data in the low bits.
- err_clr  in  1  clears err_sticky.
- RD  out  32  load result, registered.
- rd_valid  out  1  one-cycle pulse: RD updated by a completed load.
- misalign  out  1  one-cycle pulse: previous-cycle request was misaligned or used size=11.
- oob  out  1  one-cycle pulse: previous-cycle request addressed word index >= DEPTH, or had nonzero bits above the index.
- err_sticky  out  1  set by any misalign/oob event; held until err_clr or reset.

Behaviour:
- Reset (rst_n=0, asynchronous): RD=0, rd_valid=0, misalign=0, oob=0, err_sticky=0. The memory array is not modified by reset. Reset asserted mid-access aborts any pending read result.
- Word index = A[log2(DEPTH)+1:2]; lane = A[1:0].
- Alignment rules:
  - Byte: any lane is legal.
  - Half: requires A[0]=0.
  - Word: requires A[1:0]=00.
  - size=11 is treated as misaligned.
- Request = WE | memread. Every faulty request is fully suppressed: no array write, RD unchanged, rd_valid=0. In the following cycle, misalign and/or oob pulse high for one cycle and err_sticky sets.
- Store (WE=1, legal):
  - Byte: only lane A[1:0] is written with WD[7:0].
  - Half: lanes {A[1],0} and {A[1],1} are written with WD[15:0], little-endian.
  - Word: all four lanes are written.
  - Unselected lanes retain their values.
- Load (memread=1, legal): at the next posedge, RD = selected lane(s), extended per sign_ext, and rd_valid=1 for exactly that cycle. With size=10, sign_ext is ignored.
- No load in a cycle: RD holds its last value and rd_valid=0.
- WE and memread both high in the same cycle is read-first: RD returns the pre-store contents, and the store is visible to the next load.
- Back-to-back loads sustain one result per cycle; there are no stall cycles.
- err_clr and a new error in the same cycle: the set wins, so err_sticky=1.
- X on WE/memread is not tolerated; the bench keeps them at known values.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - function is_aligned(size, lane);
  - localparam IDX_W = $clog2(DEPTH) is computed in the module.
- One combinational sub-module, dmem_lane_align, provides:
  - store side: 4-bit byte-enable and lane-replicated write data from (size, lane, WD);
  - load side: extraction and sign/zero extension from (size, lane, sign_ext, word).
- The top module holds the array, read register, error pulses and sticky flag.

Test Plan:
- Reset, then word load from A=0x14 (INIT_PATTERN=1) -> RD=0x00000005 and rd_valid=1 one cycle after memread; no misalign or oob pulse.
- sw 0x8899AABB at A=0x20; lb at A=0x21 with sign_ext=1 -> RD=0xFFFFFFAA; lbu at 0x23 -> 0x00000088; lh at 0x22 with sign_ext=1 -> 0xFFFF8899.
- sb 0x5A at A=0x11, then lw at 0x10 -> RD=0x00005A04, all other lanes unchanged.
- lw at A=0x06 -> misalign pulse, err_sticky=1, RD and rd_valid unchanged. sh at A=0x03 -> suppressed, array unchanged. err_clr -> err_sticky=0.
- lw at A=4*DEPTH (DEPTH=64, A=0x100) -> oob pulse and no rd_valid. sw to the same address -> no write anywhere; word 0 still reads 0x00000000.
- WE and memread both high at A=0x08 with WD=0xDEADBEEF -> RD=0x00000002 (read-first); next lw at 0x08 -> 0xDEADBEEF. Then assert rst_n=0 mid-sequence -> all outputs 0 immediately, and array contents are retained after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access-size encodings
// and the alignment rule used by both the memory and its lane steering.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // True when an access of the given size may start at the given byte lane.
    // The reserved size code is never aligned, so it is reported as misaligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// on the write side, lane extraction and sign/zero extension on the read side.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: select the byte lanes to write and place the data in every lane.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        o_be    = 4'b0000;
        o_wdata = i_wd;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wd[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wd[15:0]}};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wd;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_wd;
            end
        endcase
    end

    // Load side: pick the addressed lane(s) from the word and extend to 32 bits.
    always_comb begin
        w_byte    = i_word[8*i_lane +: 8];
        w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_ld_data = i_word;
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{w_byte[7] & i_sign_ext}}, w_byte};
            SZ_HALF: o_ld_data = {{16{w_half[15] & i_sign_ext}}, w_half};
            default: o_ld_data = i_word;
        endcase
    end

endmodule

// File: rtl/datamem_bytelane.sv
// MEM-stage data memory with byte/half/word access, 1-cycle registered loads,
// suppression of misaligned and out-of-range requests, and a sticky error flag.
module datamem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = 32,
    parameter int INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic              memread,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              err_clr,
    output logic [31:0]       RD,
    output logic              rd_valid,
    output logic              misalign,
    output logic              oob,
    output logic              err_sticky
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_req;
    logic             w_oob_addr;
    logic             w_misalign;
    logic             w_oob;
    logic             w_fault;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld_data;
    logic [31:0]      w_words [DEPTH];

    assign w_idx  = A[IDX_W+1:2];
    assign w_lane = A[1:0];
    assign w_req  = WE | memread;

    // Any address bit above the word index makes the access out of range.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_hi_bits
            assign w_oob_addr = |A[ADDR_W-1:IDX_W+2];
        end else begin : g_no_hi_bits
            assign w_oob_addr = 1'b0;
        end
    endgenerate

    assign w_misalign = w_req & ~is_aligned(size, w_lane);
    assign w_oob      = w_req & w_oob_addr;
    assign w_fault    = w_misalign | w_oob;

    dmem_lane_align u_align (
        .i_size     (size),
        .i_lane     (w_lane),
        .i_sign_ext (sign_ext),
        .i_wd       (WD),
        .i_word     (w_words[w_idx]),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    // One storage word per index, preloaded with either its index or zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [31:0] r_word = (INIT_PATTERN != 0) ? 32'(gi) : 32'd0;

        // Byte-lane write of this word on a legal store addressed to it.
        // NOTE: the storage has no reset branch; reset must leave memory contents intact.
        always_ff @(posedge clk) begin
            if (WE && !w_fault && (w_idx == IDX_W'(gi))) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_word[8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign w_words[gi] = r_word;
    end

    // Registered load result with a one-cycle valid strobe; read-first against a same-cycle store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD       <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            rd_valid <= memread & ~w_fault;
            if (memread && !w_fault) begin
                RD <= w_ld_data;
            end
        end
    end

    // Error pulses for the cycle after a faulty request; sticky flag where set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign   <= 1'b0;
            oob        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            misalign <= w_misalign;
            oob      <= w_oob;
            if (w_fault) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_datamem_bytelane.sv
// Directed bench for datamem_bytelane: each step drives one request and pushes
// the expected registered outputs to a scoreboard, popped one edge later.
module tb_datamem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WE;
    logic        memread;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] A;
    logic [31:0] WD;
    logic        err_clr;
    logic [31:0] RD;
    logic        rd_valid;
    logic        misalign;
    logic        oob;
    logic        err_sticky;

    typedef struct {
        logic [31:0] rd;
        logic        valid;
        logic        mis;
        logic        oob;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    datamem_bytelane #(.DEPTH(64), .ADDR_W(32), .INIT_PATTERN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .WE         (WE),
        .memread    (memread),
        .size       (size),
        .sign_ext   (sign_ext),
        .A          (A),
        .WD         (WD),
        .err_clr    (err_clr),
        .RD         (RD),
        .rd_valid   (rd_valid),
        .misalign   (misalign),
        .oob        (oob),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Compare the oldest scoreboard entry against the outputs now on the pins.
    task automatic pop_and_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check32({e.tag, ".RD"}, RD, e.rd);
        check1({e.tag, ".rd_valid"}, rd_valid, e.valid);
        check1({e.tag, ".misalign"}, misalign, e.mis);
        check1({e.tag, ".oob"}, oob, e.oob);
        check1({e.tag, ".err_sticky"}, err_sticky, e.err);
    endtask

    // One request cycle: drive at negedge, record expectation, sample 1 ns after posedge.
    task automatic step(input string tag, input logic we_i, input logic rd_i,
                        input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic clr,
                        input logic [31:0] e_rd, input logic e_v, input logic e_mis,
                        input logic e_oob, input logic e_err);
        exp_t e;
        @(negedge clk);
        WE = we_i; memread = rd_i; size = sz; sign_ext = sx; A = a; WD = wd; err_clr = clr;
        e.rd = e_rd; e.valid = e_v; e.mis = e_mis; e.oob = e_oob; e.err = e_err; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, ".RD"}, RD, 32'd0);
        check1({tag, ".rd_valid"}, rd_valid, 1'b0);
        check1({tag, ".misalign"}, misalign, 1'b0);
        check1({tag, ".oob"}, oob, 1'b0);
        check1({tag, ".err_sticky"}, err_sticky, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; WE = 1'b0; memread = 1'b0; size = 2'b10; sign_ext = 1'b0;
        A = 32'd0; WD = 32'd0; err_clr = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //   tag           WE    rd    size   sx    A           WD            clr   RD            v     mis   oob   err
        step("lw_14",      1'b0, 1'b1, 2'b10, 1'b0, 32'h14,     32'h0,        1'b0, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b0);
        step("idle",       1'b0, 1'b0, 2'b10, 1'b0, 32'h0,      32'h0,        1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sw_20",      1'b1, 1'b0, 2'b10, 1'b0, 32'h20,     32'h8899AABB, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lb_21",      1'b0, 1'b1, 2'b00, 1'b1, 32'h21,     32'h0,        1'b0, 32'hFFFFFFAA, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lbu_23",     1'b0, 1'b1, 2'b00, 1'b0, 32'h23,     32'h0,        1'b0, 32'h00000088, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lh_22",      1'b0, 1'b1, 2'b01, 1'b1, 32'h22,     32'h0,        1'b0, 32'hFFFF8899, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sb_11",      1'b1, 1'b0, 2'b00, 1'b0, 32'h11,     32'h0000005A, 1'b0, 32'hFFFF8899, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_10",      1'b0, 1'b1, 2'b10, 1'b0, 32'h10,     32'h0,        1'b0, 32'h00005A04, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lw_06_mis",  1'b0, 1'b1, 2'b10, 1'b0, 32'h06,     32'h0,        1'b0, 32'h00005A04, 1'b0, 1'b1, 1'b0, 1'b1);
        step("sh_03_mis",  1'b1, 1'b0, 2'b01, 1'b0, 32'h03,     32'hFFFFFFFF, 1'b0, 32'h00005A04, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lw_00_kept", 1'b0, 1'b1, 2'b10, 1'b0, 32'h00,     32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("err_clr",    1'b0, 1'b0, 2'b10, 1'b0, 32'h00,     32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_100_oob", 1'b0, 1'b1, 2'b10, 1'b0, 32'h100,    32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1);
        step("sw_oob_clr", 1'b1, 1'b0, 2'b10, 1'b0, 32'h100,    32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1);
        step("lw_04",      1'b0, 1'b1, 2'b10, 1'b0, 32'h04,     32'h0,        1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1);
        step("lw_00_oob",  1'b0, 1'b1, 2'b10, 1'b0, 32'h00,     32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("err_clr2",   1'b0, 1'b0, 2'b10, 1'b0, 32'h00,     32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sz11_mis",   1'b0, 1'b1, 2'b11, 1'b0, 32'h0C,     32'h0,        1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lh_01_mis",  1'b0, 1'b1, 2'b01, 1'b0, 32'h01,     32'h0,        1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1);
        step("err_clr3",   1'b0, 1'b0, 2'b10, 1'b0, 32'h00,     32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rw_08",      1'b1, 1'b1, 2'b10, 1'b0, 32'h08,     32'hDEADBEEF, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lw_08",      1'b0, 1'b1, 2'b10, 1'b1, 32'h08,     32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lhu_0a",     1'b0, 1'b1, 2'b01, 1'b0, 32'h0A,     32'h0,        1'b0, 32'h0000DEAD, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lb_09",      1'b0, 1'b1, 2'b00, 1'b1, 32'h09,     32'h0,        1'b0, 32'hFFFFFFBE, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sw_1c_err",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0400001C, 32'h0,      1'b0, 32'hFFFFFFBE, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a pending load: outputs clear at once, no result appears.
        @(negedge clk);
        WE = 1'b0; memread = 1'b1; size = 2'b10; sign_ext = 1'b0; A = 32'h14; err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        memread = 1'b0;
        rst_n = 1'b1;

        step("post_idle",  1'b0, 1'b0, 2'b10, 1'b0, 32'h00,     32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("kept_08",    1'b0, 1'b1, 2'b10, 1'b0, 32'h08,     32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("kept_20",    1'b0, 1'b1, 2'b10, 1'b0, 32'h20,     32'h0,        1'b0, 32'h8899AABB, 1'b1, 1'b0, 1'b0, 1'b0);
        step("kept_1c",    1'b0, 1'b1, 2'b10, 1'b0, 32'h1C,     32'h0,        1'b0, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0);

        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
